// File: rtl/route_reserve_arbiter_pkg.sv
// Shared definitions for the route-reserve switch allocator: FSM encoding,
// default sizing and the round-robin pick function.
package route_reserve_arbiter_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StBusy  = 2'd2;

  localparam int unsigned DefaultPorts = 5;
  localparam int unsigned PortIdxW     = 3;
  localparam int unsigned MaxPorts     = 16;
  localparam int unsigned MaxIdxW      = $clog2(MaxPorts);

  // First set bit of mask scanning ptr, ptr+1, ... modulo n; returns ptr when mask is empty.
  function automatic int unsigned rr_pick(input logic [MaxPorts-1:0] mask,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned cand;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < MaxPorts; k++) begin
      cand = ptr + k;
      if (cand >= n) cand = cand - n;
      if (k < n && !found && mask[cand[MaxIdxW-1:0]]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/route_reserve_arbiter_arb.sv
// Combinational round-robin 1-of-N arbiter: request mask and pointer in,
// one-hot grant and winning index out.
module rr_arbiter_1ofn
  import route_reserve_arbiter_pkg::*;
#(
  parameter int unsigned N = DefaultPorts,
  parameter int unsigned W = PortIdxW
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);

  logic [MaxPorts-1:0] wideMask;

  always_comb begin
    wideMask        = '0;
    wideMask[N-1:0] = mask;
    idx             = W'(rr_pick(wideMask, 32'(ptr), N));
    grant           = '0;
    if (|mask) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/route_reserve_arbiter.sv
// Switch allocator: per-output round-robin IDLE/GRANT/BUSY FSMs holding the crossbar binding.
// Define ROUTE_ARB_WATCHDOG_EN to add a per-output BUSY hold-limit watchdog.
module route_reserve_arbiter
  import route_reserve_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = DefaultPorts,
  parameter int unsigned REQUEST_WIDTH = PortIdxW,
  parameter int unsigned HOLD_LIMIT    = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0]               req_valid,
  input  logic [NUM_PORTS*REQUEST_WIDTH-1:0] req_port,
  input  logic [NUM_PORTS-1:0]               release_req,
  output logic [NUM_PORTS-1:0]               reserve_status,
  output logic [NUM_PORTS-1:0]               out_busy,
  output logic [NUM_PORTS*REQUEST_WIDTH-1:0] out_owner
`ifdef ROUTE_ARB_WATCHDOG_EN
  ,
  output logic [NUM_PORTS-1:0]               wd_expired
`endif
);

  if (REQUEST_WIDTH < $clog2(NUM_PORTS) || NUM_PORTS > MaxPorts || HOLD_LIMIT == 0)
  begin : gBadParams
    $error("route_reserve_arbiter: illegal parameter combination");
  end

  logic [1:0]               state     [NUM_PORTS];
  logic [REQUEST_WIDTH-1:0] owner     [NUM_PORTS];
  logic [REQUEST_WIDTH-1:0] rrPtr     [NUM_PORTS];
  logic [NUM_PORTS-1:0]     cand      [NUM_PORTS];
  logic [NUM_PORTS-1:0]     winOneHot [NUM_PORTS];
  logic [REQUEST_WIDTH-1:0] winIdx    [NUM_PORTS];
  logic [NUM_PORTS-1:0]     owned;

`ifdef ROUTE_ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(HOLD_LIMIT + 1);
  logic [CntW-1:0]      wdCnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] wdFlag;
  assign wd_expired = wdFlag;
`endif

  always_comb begin
    owned = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state[o] != StIdle) owned[owner[o]] = 1'b1;
    end
  end

  // Each input names a single output, so two outputs can never pick the same input
  // in one cycle; excluding current owners is all that keeps bindings exclusive.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand[o][i] = req_valid[i] && !owned[i] &&
                     (req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(o));
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : gArb
    rr_arbiter_1ofn #(
      .N(NUM_PORTS),
      .W(REQUEST_WIDTH)
    ) uArb (
      .mask (cand[o]),
      .ptr  (rrPtr[o]),
      .grant(winOneHot[o]),
      .idx  (winIdx[o])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state[o] <= StIdle;
        owner[o] <= '0;
        rrPtr[o] <= '0;
`ifdef ROUTE_ARB_WATCHDOG_EN
        wdCnt[o] <= '0;
`endif
      end
`ifdef ROUTE_ARB_WATCHDOG_EN
      wdFlag <= '0;
`endif
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
`ifdef ROUTE_ARB_WATCHDOG_EN
        wdCnt[o] <= '0;
`endif
        case (state[o])
          StIdle: begin
            if (|winOneHot[o]) begin
              state[o] <= StGrant;
              owner[o] <= winIdx[o];
              rrPtr[o] <= (winIdx[o] == REQUEST_WIDTH'(NUM_PORTS - 1)) ? '0
                                                                       : winIdx[o] + 1'b1;
            end
          end
          StGrant: state[o] <= StBusy;
          StBusy: begin
            if (release_req[owner[o]]) begin
              state[o] <= StIdle;
`ifdef ROUTE_ARB_WATCHDOG_EN
            end else if (wdCnt[o] == CntW'(HOLD_LIMIT - 1)) begin
              state[o]  <= StIdle;
              wdFlag[o] <= 1'b1;
            end else begin
              wdCnt[o] <= wdCnt[o] + 1'b1;
`endif
            end
          end
          default: state[o] <= StIdle;
        endcase
      end
    end
  end

  // Status is masked during reset so a GRANT cycle cut short by rst never pulses.
  always_comb begin
    reserve_status = '0;
    out_busy       = '0;
    out_owner      = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_busy[o] = (state[o] != StIdle);
      out_owner[o*REQUEST_WIDTH +: REQUEST_WIDTH] = owner[o];
      if (state[o] == StGrant && !rst) reserve_status[owner[o]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_route_reserve_arbiter.sv
// Directed self-checking bench for route_reserve_arbiter (5 ports, 3-bit indices, hold limit 8).
module tb_route_reserve_arbiter;

  localparam int unsigned NP = 5;
  localparam int unsigned RW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] req_valid = '0;
  logic [NP-1:0] release_req = '0;
  logic [RW-1:0] reqPort [NP];
  logic [NP*RW-1:0] req_port;
  logic [NP-1:0] reserve_status;
  logic [NP-1:0] out_busy;
  logic [NP*RW-1:0] out_owner;
`ifdef ROUTE_ARB_WATCHDOG_EN
  logic [NP-1:0] wd_expired;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_port = '0;
    for (int i = 0; i < NP; i++) req_port[i*RW +: RW] = reqPort[i];
  end

  route_reserve_arbiter #(
    .NUM_PORTS    (NP),
    .REQUEST_WIDTH(RW),
    .HOLD_LIMIT   (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_port      (req_port),
    .release_req   (release_req),
    .reserve_status(reserve_status),
    .out_busy      (out_busy),
    .out_owner     (out_owner)
`ifdef ROUTE_ARB_WATCHDOG_EN
    ,
    .wd_expired    (wd_expired)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] ownerOf(input int o);
    return out_owner[o*RW +: RW];
  endfunction

  initial begin
    int            nGrant;
    int            relAt;
    logic [RW-1:0] curOwner;
    logic [RW-1:0] order [4];
    order    = '{3'd0, 3'd1, 3'd4, 3'd0};
    nGrant   = 0;
    relAt    = -1;
    curOwner = '0;
    for (int i = 0; i < NP; i++) reqPort[i] = '0;

    tick();
    tick();
    check("rst_status", 32'(reserve_status), 32'h0);
    check("rst_busy", 32'(out_busy), 32'h0);
    check("rst_owner", 32'(out_owner), 32'h0);
`ifdef ROUTE_ARB_WATCHDOG_EN
    check("rst_wd", 32'(wd_expired), 32'h0);
`endif
    rst = 1'b0;

    // Single request: input 2 -> output 3
    reqPort[2] = 3'd3;
    req_valid  = 5'b00100;
    tick();
    check("single_status", 32'(reserve_status), 32'h04);
    check("single_busy", 32'(out_busy), 32'h08);
    check("single_owner", 32'(ownerOf(3)), 32'd2);
    req_valid = '0;
    tick();
    check("single_pulse_end", 32'(reserve_status), 32'h0);
    check("single_hold", 32'(out_busy), 32'h08);
    release_req = 5'b00100;
    tick();
    release_req = '0;
    check("single_release", 32'(out_busy), 32'h0);

    // Contention on output 1 from inputs 0, 1, 4; each owner releases 3 cycles after grant
    reqPort[0] = 3'd1;
    reqPort[1] = 3'd1;
    reqPort[4] = 3'd1;
    req_valid  = 5'b10011;
    for (int cyc = 0; cyc < 40 && nGrant < 4; cyc++) begin
      release_req = '0;
      if (cyc == relAt) release_req[curOwner] = 1'b1;
      tick();
      if (cyc == relAt) check("cont_bubble", 32'(out_busy), 32'h0);
      if (reserve_status != '0) begin
        check("cont_grant", 32'(reserve_status), 32'd1 << order[nGrant]);
        check("cont_owner", 32'(ownerOf(1)), 32'(order[nGrant]));
        curOwner = order[nGrant];
        relAt    = cyc + 3;
        nGrant++;
      end
    end
    check("cont_count", 32'(nGrant), 32'd4);
    req_valid   = '0;
    release_req = '0;
    tick();
    release_req = 5'b00001;
    tick();
    release_req = '0;
    check("cont_final", 32'(out_busy), 32'h0);

    // Parallel grants: input 0 -> output 2, input 3 -> output 4
    reqPort[0] = 3'd2;
    reqPort[3] = 3'd4;
    req_valid  = 5'b01001;
    tick();
    check("par_status", 32'(reserve_status), 32'h09);
    check("par_busy", 32'(out_busy), 32'h14);
    check("par_owner2", 32'(ownerOf(2)), 32'd0);
    check("par_owner4", 32'(ownerOf(4)), 32'd3);
    req_valid = '0;
    tick();

    // Non-owner release and an out-of-range request
    release_req = 5'b00010;
    reqPort[1]  = 3'd7;
    req_valid   = 5'b00010;
    tick();
    release_req = '0;
    check("nonown_busy", 32'(out_busy), 32'h14);
    check("nonown_owner2", 32'(ownerOf(2)), 32'd0);
    check("oor_status", 32'(reserve_status), 32'h0);
    release_req = 5'b01001;
    tick();
    release_req = '0;
    check("par_release", 32'(out_busy), 32'h0);
    tick();
    tick();
    check("oor_idle_status", 32'(reserve_status), 32'h0);
    check("oor_idle_busy", 32'(out_busy), 32'h0);
    req_valid = '0;

    // Reset mid-operation with the request held
    reqPort[2] = 3'd3;
    req_valid  = 5'b00100;
    tick();
    check("rmid_grant", 32'(reserve_status), 32'h04);
    tick();
    check("rmid_busy", 32'(out_busy), 32'h08);
    rst = 1'b1;
    tick();
    check("rmid_busy0", 32'(out_busy), 32'h0);
    check("rmid_owner0", 32'(out_owner), 32'h0);
    check("rmid_status0", 32'(reserve_status), 32'h0);
    rst = 1'b0;
    tick();
    check("rmid_regrant", 32'(reserve_status), 32'h04);
    check("rmid_rebusy", 32'(out_busy), 32'h08);
    rst = 1'b1;
    #1;
    check("rmid_no_pulse", 32'(reserve_status), 32'h0);
    tick();
    rst       = 1'b0;
    req_valid = '0;
    check("rmid_clear", 32'(out_busy), 32'h0);

`ifdef ROUTE_ARB_WATCHDOG_EN
    // Watchdog: input 4 -> output 0, never released
    reqPort[4] = 3'd0;
    req_valid  = 5'b10000;
    tick();
    check("wd_grant", 32'(reserve_status), 32'h10);
    req_valid = '0;
    for (int k = 0; k < 8; k++) tick();
    check("wd_held", 32'(out_busy), 32'h01);
    check("wd_not_yet", 32'(wd_expired), 32'h0);
    tick();
    check("wd_free", 32'(out_busy), 32'h0);
    check("wd_flag", 32'(wd_expired), 32'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/route_reserve_arbiter.md
Name: route_reserve_arbiter

Overview:
- Switch allocator for one router.
- Collects route-reserve requests from NUM_PORTS input ports; each request names one output port.
- Grants each output to at most one input at a time, using per-output round-robin.
- Returns a one-cycle reserve-status pulse to the winning input.
- Holds the output/input binding for the crossbar until the owning input signals release (tail flit forwarded).

Parameters:
- NUM_PORTS, 5: number of input ports and of output ports (router radix).
- REQUEST_WIDTH, 3: width of each request field, an output-port index. Must be at least clog2(NUM_PORTS).
- HOLD_LIMIT, 64: watchdog hold limit in cycles. Used only when the watchdog macro is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_PORTS  bit i high means input i has a pending route-reserve request.
- req_port  in  NUM_PORTS*REQUEST_WIDTH  slice i is the output index requested by input i.
- release  in  NUM_PORTS  bit i high for one cycle means input i has forwarded its tail flit and frees its output.
- reserve_status  out  NUM_PORTS  bit i is a one-cycle grant pulse to input i.
- out_busy  out  NUM_PORTS  bit o high means output o is reserved.
- out_owner  out  NUM_PORTS*REQUEST_WIDTH  slice o is the input owning output o; this is the crossbar select.
- wd_expired  out  NUM_PORTS  per-output watchdog flag. Present only when the macro is defined.

Behaviour:
- Reset values: reserve_status=0, out_busy=0, out_owner=0, every rr_ptr=0, every output FSM in IDLE, wd_expired=0.
- Per-output FSM states: IDLE, GRANT, BUSY.
- IDLE:
  - Candidates are inputs i with req_valid[i]=1 and req_port[i]==o, excluding any input that currently owns some output or is being granted this cycle.
  - If any candidate exists: select the first candidate scanning rr_ptr, rr_ptr+1, … with wrap modulo NUM_PORTS.
  - At the next edge: state←GRANT, out_owner[o]←winner, out_busy[o]←1, rr_ptr[o]←(winner+1) mod NUM_PORTS.
- GRANT:
  - reserve_status[owner]=1 for exactly this cycle.
  - Next state is BUSY unconditionally.
- BUSY:
  - When release[out_owner[o]]=1, next state is IDLE and out_busy[o]←0.
  - release bits from non-owners are ignored.
- Latency: a request sampled in cycle t gives reserve_status high in cycle t+1 and out_busy high from t+1.
- Request lifetime: the requester keeps the request valid until it sees status. A request still visible during GRANT or BUSY is ignored because the output is not IDLE.
- Release and re-arbitration: release and a new request in the same cycle → the output is IDLE in the next cycle and arbitrates then. Minimum one bubble between owners; this is the intended behaviour.
- Out-of-range requests: req_port ≥ NUM_PORTS is never granted and has no side effects.
- Multiple outputs in one cycle: several outputs may grant in the same cycle, to distinct inputs. reserve_status[i] is the OR of GRANT pulses naming i.
- Reset mid-operation: all reservations are dropped and FSMs return to IDLE the next cycle. No status pulse is emitted in that cycle.
- Release in GRANT: release asserted during GRANT is ignored. The owner must release in BUSY.

Optional Feature:
- Macro: ROUTE_ARB_WATCHDOG_EN.
- Defined:
  - Each output keeps a counter of BUSY cycles, sized clog2(HOLD_LIMIT+1).
  - When the counter reaches HOLD_LIMIT, the output forces BUSY→IDLE and sets wd_expired[o] (sticky until rst). The counter clears on leaving BUSY.
- Undefined:
  - No counter and no wd_expired port.
  - BUSY is held indefinitely until release.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE=2'd0, GRANT=2'd1, BUSY=2'd2.
  - Function rr_pick(mask, ptr) returning the winning index.
  - Port-index width constant.
- One sub-module, rr_arbiter_1ofn: request mask and pointer in, one-hot and index out, purely combinational.
- The top instantiates one rr_arbiter_1ofn per output and holds the per-output FSMs and ownership registers.

Test Plan:
- Single request: req_valid=5'b00100, req_port[2]=3 at cycle 10 → reserve_status=5'b00100 only at cycle 11; out_busy[3]=1; out_owner[3]=2. A release[2] pulse → out_busy[3]=0 one cycle later.
- Contention: inputs 0, 1 and 4 all request output 1 continuously, each releasing 3 cycles after its grant → grant order 0, 1, 4, 0; never two owners at once.
- Parallel grants: input0→out2 and input3→out4 in the same cycle → both status bits pulse in the same cycle; out_owner[2]=0 and out_owner[4]=3.
- Non-owner release and out-of-range request: release[1] while output 2 is owned by 0 → no change. req_port=7 with NUM_PORTS=5 → never granted.
- Reset mid-operation: rst during BUSY on output 3 → all outputs zero next cycle, and the pending request is re-granted after rst drops.
- Watchdog: with ROUTE_ARB_WATCHDOG_EN and HOLD_LIMIT=8, no release → output returns to IDLE after 8 BUSY cycles and wd_expired[o]=1.
